serial_add_ctrl: RTL and testbench

- Bit-serial add/subtract sequencer that time-shares one 1-bit full-add cell across WIDTH-bit operands, LSB first.
- Full-add cell is instantiated inside the block: S = A^B^C, carry = majority(A,B,C).
- Sits between game-logic producers (score/combo counters) and their consumers, trading latency for area.
- start/busy/done handshake; result is held stable until the next accepted start.

---
 rtl/serial_add_ctrl.sv | 130 +++++++++++++
 tb/tb_serial_add_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: one shared full-add cell walks WIDTH-bit operands LSB first.
// Optional signed saturation on overflow when SERIAL_ADD_SAT_EN is defined.

module serial_add_fa (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ c;
  assign co = (a & b) | (a & c) | (b & c);
endmodule

module serial_add_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   a_reg, b_reg, sum_reg;
  logic [CNT_W-1:0]   cnt;
  logic               carry, msb_cin;
  logic               cell_s, cell_co;
  logic               last_bit;
  logic [WIDTH-1:0]   sum_full;
`ifdef SERIAL_ADD_SAT_EN
  logic               a_sign;
`endif

  serial_add_fa u_fa (
    .a  (a_reg[0]),
    .b  (b_reg[0]),
    .c  (carry),
    .s  (cell_s),
    .co (cell_co)
  );

  assign last_bit = (cnt == CNT_W'(WIDTH-1));
  assign sum_full = {cell_s, sum_reg[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      cnt       <= '0;
      carry     <= 1'b0;
      msb_cin   <= 1'b0;
      result    <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
`ifdef SERIAL_ADD_SAT_EN
      a_sign    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          a_reg <= op_a;
          b_reg <= sub ? ~op_b : op_b;
          carry <= sub;
          cnt   <= '0;
`ifdef SERIAL_ADD_SAT_EN
          a_sign <= op_a[WIDTH-1];
`endif
        end
        RUN: begin
          a_reg   <= a_reg >> 1;
          b_reg   <= b_reg >> 1;
          sum_reg <= sum_full;
          carry   <= cell_co;
          cnt     <= cnt + 1'b1;
          if (last_bit) begin
            msb_cin   <= carry;
            carry_out <= cell_co;
            overflow  <= carry ^ cell_co;
`ifdef SERIAL_ADD_SAT_EN
            // Overflow implies both operand signs agree, so A's sign picks the limit.
            if (carry ^ cell_co)
              result <= a_sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
            else
              result <= sum_full;
`else
            result <= sum_full;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed bench for serial_add_ctrl (WIDTH=8): reset, add/sub, wrap, overflow, handshake.

module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, sub;
  logic [W-1:0] op_a, op_b;
  logic         busy, done, carry_out, overflow;
  logic [W-1:0] result;

  int checks = 0;
  int errors = 0;

  serial_add_ctrl #(.WIDTH(W), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .sub       (sub),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .carry_out (carry_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one op, check latency and outputs, then return to IDLE.
  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic [W-1:0] exp_r, input logic exp_c,
                        input logic exp_v);
    int n;
    op_a = a; op_b = b; sub = s; start = 1'b1;
    step();
    start = 1'b0;
    check({tag, "_busy0"}, busy, 1);
    n = 0;
    while (!done && n < 20) begin
      step();
      n++;
    end
    check({tag, "_lat"}, n, 8);
    check({tag, "_res"}, result, exp_r);
    check({tag, "_cout"}, carry_out, exp_c);
    check({tag, "_ovf"}, overflow, exp_v);
    step();
    check({tag, "_donelo"}, done, 0);
    check({tag, "_hold"}, result, exp_r);
  endtask

  initial begin
    logic [W-1:0] ovf1_r, ovf2_r;
    int ndone;
`ifdef SERIAL_ADD_SAT_EN
    ovf1_r = 8'h7F; ovf2_r = 8'h80;
`else
    ovf1_r = 8'h80; ovf2_r = 8'h7F;
`endif
    rst = 1'b1; start = 1'b0; sub = 1'b0; op_a = '0; op_b = '0;
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_res", result, 0);
    check("rst_cout", carry_out, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b0;
    step();

    run_op("add", 8'h55, 8'h0F, 1'b0, 8'h64, 1'b0, 1'b0);
    run_op("wrap", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("sub_neg", 8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
    run_op("sub_pos", 8'h20, 8'h10, 1'b1, 8'h10, 1'b1, 1'b0);
    run_op("ovf_add", 8'h7F, 8'h01, 1'b0, ovf1_r, 1'b0, 1'b1);
    run_op("ovf_sub", 8'h80, 8'h01, 1'b1, ovf2_r, 1'b1, 1'b1);
    run_op("add2", 8'h55, 8'h0F, 1'b0, 8'h64, 1'b0, 1'b0);

    // Reset mid-RUN: start at edge 0, rst sampled at edge 3.
    op_a = 8'h55; op_b = 8'h0F; sub = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_res", result, 0);
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done) ndone++;
    end
    check("abort_nodone", ndone, 0);
    check("abort_idle", busy, 0);

    // Starts at edges 2 and 8 ignored; op_a change mid-RUN has no effect.
    op_a = 8'h55; op_b = 8'h0F; sub = 1'b0; start = 1'b1;
    step();
    for (int e = 1; e <= 9; e++) begin
      start = (e == 2 || e == 8);
      if (e == 3) op_a = 8'hAA;
      step();
      if (e <= 7) check("hs_busy", busy, 1);
      if (e == 8) begin
        check("hs_done", done, 1);
        check("hs_res", result, 8'h64);
      end
      if (e == 9) begin
        check("hs_idle_busy", busy, 0);
        check("hs_idle_done", done, 0);
      end
    end
    start = 1'b0;
    step();
    check("hs_norestart", busy, 0);

    // Held start: done after edges 8, 18, 28 counted from the accepting edge.
    op_a = 8'h01; op_b = 8'h01; sub = 1'b0; start = 1'b1;
    for (int c = 0; c < 30; c++) begin
      step();
      check("held_done", done, (c % 10) == 8);
    end
    check("held_res", result, 8'h02);
    start = 1'b0;
    for (int i = 0; i < 12; i++) step();
    check("held_drain", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
